// File: rtl/dct_pkg.sv
// Shared block geometry and types for the 8x8 block collection / DCT chain.
package dct_pkg;

    localparam int unsigned BLK_DIM    = 8;
    localparam int unsigned BLK_SIZE   = 64;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned BLK_DATA_W = 32;

    typedef logic [IDX_W-1:0] blk_idx_t;
    typedef logic [BLK_DIM-1:0][BLK_DIM-1:0][BLK_DATA_W-1:0] block_t;

endpackage

// File: rtl/block_bank.sv
// One 8x8 register bank with its full flag; written one element per beat.
module block_bank
    import dct_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                                              clk,
    input  logic                                              rst_n,
    input  logic                                              we_i,
    input  blk_idx_t                                          idx_i,
    input  logic [DATA_WIDTH-1:0]                             wdata_i,
    input  logic                                              set_full_i,
    input  logic                                              clr_full_i,
    output logic [BLK_DIM-1:0][BLK_DIM-1:0][DATA_WIDTH-1:0]   data_o,
    output logic                                              full_o
);

    logic [BLK_DIM-1:0][BLK_DIM-1:0][DATA_WIDTH-1:0] mem_q;
    logic                                            full_q;
    logic                                            full_d;

    // set and clear never coincide: set only while empty, clear only while full
    always_comb begin
        full_d = full_q;
        if (set_full_i) begin
            full_d = 1'b1;
        end else if (clr_full_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '0;
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (we_i) begin
                mem_q[idx_i[5:3]][idx_i[2:0]] <= wdata_i;
            end
        end
    end

    assign data_o = mem_q;
    assign full_o = full_q;

endmodule

// File: rtl/block_collector.sv
// Collects a raster pixel stream into 8x8 blocks using two ping-pong banks.
module block_collector
    import dct_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 10,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                                              CLOCK,
    input  logic                                              RESET,
    input  logic                                              input_valid,
    output logic                                              input_ready,
    input  logic [PIXEL_WIDTH-1:0]                            INPUT_PIXEL,
    output logic                                              output_valid,
    input  logic                                              output_ready,
    output logic [BLK_DIM-1:0][BLK_DIM-1:0][DATA_WIDTH-1:0]   OUTPUT_DATA
);

    localparam blk_idx_t LAST_IDX = blk_idx_t'(BLK_SIZE - 1);

    blk_idx_t idx_q, idx_d;
    logic     wr_sel_q, wr_sel_d;
    logic     rd_sel_q, rd_sel_d;

    logic [1:0] full;
    logic [1:0] we;
    logic [1:0] set_full;
    logic [1:0] clr_full;
    logic [BLK_DIM-1:0][BLK_DIM-1:0][DATA_WIDTH-1:0] bank_data [2];

    logic                  accept;
    logic                  rel;
    logic [DATA_WIDTH-1:0] pix_ext;

    assign input_ready  = !full[wr_sel_q];
    assign output_valid = full[rd_sel_q];
    assign OUTPUT_DATA  = bank_data[rd_sel_q];
    assign accept       = input_valid && input_ready;
    assign rel          = output_valid && output_ready;
    assign pix_ext      = DATA_WIDTH'(INPUT_PIXEL);

    // completion and release always hit different banks, so both may fire together
    always_comb begin
        idx_d    = idx_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        we       = '0;
        set_full = '0;
        clr_full = '0;
        if (accept) begin
            we[wr_sel_q] = 1'b1;
            if (idx_q == LAST_IDX) begin
                set_full[wr_sel_q] = 1'b1;
                wr_sel_d           = !wr_sel_q;
                idx_d              = '0;
            end else begin
                idx_d = idx_q + blk_idx_t'(1);
            end
        end
        if (rel) begin
            clr_full[rd_sel_q] = 1'b1;
            rd_sel_d           = !rd_sel_q;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            idx_q    <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            idx_q    <= idx_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        block_bank #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk        (CLOCK),
            .rst_n      (RESET),
            .we_i       (we[g]),
            .idx_i      (idx_q),
            .wdata_i    (pix_ext),
            .set_full_i (set_full[g]),
            .clr_full_i (clr_full[g]),
            .data_o     (bank_data[g]),
            .full_o     (full[g])
        );
    end

endmodule

// File: doc/block_collector.md
Name: block_collector

Overview:
- Gathers a serial raster-order pixel stream, one pixel per accepted beat, into complete 8x8 blocks.
- Presents each block as a full 8x8 array of 32-bit words to the level-shift/DCT chain directly downstream.
- Ping-pong buffered so input streams without bubbles while the downstream stage is ready.
- Adds a ready/valid handshake on both sides, so downstream stalls propagate back to the pixel source.

Parameters:
- PIXEL_WIDTH, 10: bit width of incoming pixel samples (unsigned).
- DATA_WIDTH, 32: width of each output array element.

Ports:
- CLOCK  input  1: single clock, rising-edge.
- RESET  input  1: asynchronous, active-low reset.
- input_valid  input  1: INPUT_PIXEL carries a valid sample.
- input_ready  output  1: block can accept a sample this cycle.
- INPUT_PIXEL  input  PIXEL_WIDTH: pixel sample, block-raster order (row 0 col 0..7, then row 1, ...).
- output_valid  output  1: OUTPUT_DATA holds a complete block.
- output_ready  input  1: downstream consumes the block this cycle.
- OUTPUT_DATA  output  DATA_WIDTH x [8][8]: block array, [row][col].

Behaviour:
- Reset: async, active-low. Clears all of the following:
  - write index to 0
  - wr_sel and rd_sel to bank 0
  - both bank_full flags to 0
  - all bank contents to 0
- Outputs while reset is asserted: output_valid=0, OUTPUT_DATA all 0, input_ready=1.
- Reset mid-block discards any partial block and any held blocks.
- Storage: two 8x8 banks of DATA_WIDTH registers.
  - wr_sel picks the bank being filled; rd_sel picks the bank being presented.
  - Each bank has a bank_full flag.
- Accept condition: input_valid && input_ready.
  - input_ready = !bank_full[wr_sel], combinational from registers.
- Write position: 6-bit write index idx. On accept:
  - bank[wr_sel][idx[5:3]][idx[2:0]] <= zero-extended INPUT_PIXEL.
  - idx increments and wraps 63 -> 0.
- Block completion, on the accept with idx==63:
  - bank_full[wr_sel] <= 1
  - wr_sel toggles
  - idx <= 0
- output_valid = bank_full[rd_sel]. OUTPUT_DATA = bank[rd_sel], a combinational mux of registers.
  - Latency: output_valid is high in the cycle after the edge that accepted pixel 63, when that bank is the read bank.
- Release, on output_valid && output_ready:
  - bank_full[rd_sel] <= 0
  - rd_sel toggles
- Hold rule: while output_valid=1 and output_ready=0, OUTPUT_DATA and output_valid stay stable.
- Simultaneous completion and release: legal, because they always target different banks. Both flag updates apply on the same edge.
  - Steady state with output_ready=1 gives 1 block per 64 accepted pixels and input_ready stays 1.
- Both banks full: input_ready=0 and idx frozen. Incoming pixels are not accepted; the source must hold them.
  - A release the same cycle frees a bank, so input_ready rises the next cycle.
- Gaps: input_valid=0 cycles do not advance idx. Partial blocks are held indefinitely; there is no timeout or flush.
- Widths: pixel zero-extended to DATA_WIDTH, never sign-extended. Downstream performs the mid-level subtraction.

Decomposition:
- Shared package (dct_pkg) holds:
  - BLK_DIM=8, BLK_SIZE=64
  - typedef blk_idx_t (6 bits)
  - typedef block_t (DATA_WIDTH x [BLK_DIM][BLK_DIM])
- One sub-module, block_bank, is natural: one 8x8 register bank plus its full flag. It has write-enable/index/data inputs, set and clear of full, and async active-low reset. Instantiate twice.
- Top level holds idx, wr_sel, rd_sel and the output mux.

Test Plan:
- Single ramp block: output_ready=1, feed pixels 0..63 back-to-back -> output_valid=1 for exactly one cycle, the cycle after pixel 63; OUTPUT_DATA[j][k]=8*j+k.
- Backpressure: output_ready=0, stream 130 pixels.
  - input_ready drops after the 128th accept; pixels 129-130 are held by the source.
  - OUTPUT_DATA stays at block 0 values.
  - Raise output_ready for one cycle -> block 1 presented next cycle, input_ready returns to 1.
- Streaming: output_ready=1, 16 consecutive blocks, random pixels -> input_ready never deasserts; each block matches the scoreboard; 16 output_valid pulses spaced 64 cycles apart.
- Valid gaps: random input_valid=0 bubbles inside a block -> same block contents as gap-free; completion timed to the 64th accept, not the cycle count.
- Max value: all pixels 0x3FF -> every OUTPUT_DATA element equals 0x000003FF (zero-extended).
- Reset mid-operation: assert RESET low asynchronously, mid-cycle, after 30 pixels of block 1 while block 0 is held.
  - Immediately: output_valid=0, OUTPUT_DATA=0, input_ready=1.
  - After release, 64 fresh pixels form a clean block with no residue.
